// File: rtl/ss_map_bank_ctrl.sv
// ss_map_bank_ctrl
//
// Owns the collision-side read port of the world-map ROM bank set and the
// bank select that drives the map muxer (clk_75 domain).
//   * Round-robin arbitration of the single map read port between the
//     player-collision (p_*) and enemy-collision (e_*) requesters.
//   * Active bank selection from the player's LocX. A bank change is only
//     committed during vertical blank, and only after every in-flight read
//     has returned, so no requester ever receives a tile from the wrong bank.
//
// Ports
//   clk_75          system clock
//   reset           asynchronous active-low reset
//   LocX            player world column; picks the target bank
//   vblank          vertical blank, level-sensitive
//   p_req/p_addr    player read request and address
//   p_gnt           one-cycle grant pulse to the player
//   p_valid/p_data  one-cycle read-return pulse and player tile (held)
//   e_*             same set for the enemy requester
//   worldmap_addr   registered address to map port A
//   worldmap_data   map port A read data
//   bank_sel        active bank: 0 = part_1, 1 = lr, 2 = loop
//   bank_switching  high while the bank FSM is in DRAIN or SWITCH
//   bank_state      current bank FSM state, for observation
//
// Request handshake (both requesters):
//   A requester raises req with a stable addr and holds both until it sees
//   gnt. The address is registered onto worldmap_addr at the edge that
//   starts the gnt cycle. A req still high during the gnt cycle is not
//   sampled, so one request is never granted twice; the requester may raise
//   req with a new address in the cycle after gnt. Read data comes back as a
//   one-cycle valid pulse exactly RD_LAT cycles after worldmap_addr updates.

module ss_map_bank_ctrl #(
    parameter logic [7:0] LR_LOCX   = 8'h7C,
    parameter logic [7:0] LOOP_LOCX = 8'hF0,
    parameter int         RD_LAT    = 2
) (
    input  logic        clk_75,
    input  logic        reset,
    input  logic [7:0]  LocX,
    input  logic        vblank,
    input  logic        p_req,
    input  logic [13:0] p_addr,
    output logic        p_gnt,
    output logic        p_valid,
    output logic [1:0]  p_data,
    input  logic        e_req,
    input  logic [13:0] e_addr,
    output logic        e_gnt,
    output logic        e_valid,
    output logic [1:0]  e_data,
    output logic [13:0] worldmap_addr,
    input  logic [1:0]  worldmap_data,
    output logic [1:0]  bank_sel,
    output logic        bank_switching,
    output logic [1:0]  bank_state
);

    localparam logic [1:0] BANK_PART1 = 2'd0;
    localparam logic [1:0] BANK_LR    = 2'd1;
    localparam logic [1:0] BANK_LOOP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_SWITCH  = 2'd3
    } bank_state_e;

    bank_state_e state_q, state_d;
    logic [1:0]  target;
    logic [1:0]  target_q;      // bank latched on entry to DRAIN
    logic        in_flight;

    // Owner tags travelling alongside each outstanding read.
    // bit 0 = player read, bit 1 = enemy read.
    logic [1:0]  tag_q [RD_LAT];

    logic        arb_en;
    logic        p_eff, e_eff;
    logic        grant_p, grant_e;
    logic        last_e_q;      // 1 = enemy was granted most recently

    // ------------------------------------------------------------------
    // Target bank: the exact lr column wins over the loop threshold.
    // ------------------------------------------------------------------
    always_comb begin
        target = BANK_PART1;
        if (LocX == LR_LOCX) begin
            target = BANK_LR;
        end else if (LocX >= LOOP_LOCX) begin
            target = BANK_LOOP;
        end
    end

    // A grant issued in the PENDING->DRAIN cycle lands in tag_q[0] at the
    // DRAIN entry edge, so it is already counted here during DRAIN.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight | (|tag_q[i]);
        end
    end

    // ------------------------------------------------------------------
    // Bank FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (target != bank_sel) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                // Revert takes priority over starting the drain.
                if (target == bank_sel) state_d = ST_IDLE;
                else if (vblank)        state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!in_flight) state_d = ST_SWITCH;
            end
            ST_SWITCH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            target_q <= BANK_PART1;
            bank_sel <= BANK_PART1;
        end else begin
            state_q <= state_d;
            if (state_q == ST_PENDING && state_d == ST_DRAIN) begin
                target_q <= target;
            end
            if (state_q == ST_SWITCH) begin
                bank_sel <= target_q;
            end
        end
    end

    assign bank_switching = (state_q == ST_DRAIN) || (state_q == ST_SWITCH);
    assign bank_state     = state_q;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_PENDING);

    // A req seen during its own gnt cycle belongs to the request just served.
    assign p_eff = p_req && !p_gnt;
    assign e_eff = e_req && !e_gnt;

    assign grant_p = arb_en && p_eff && (!e_eff || last_e_q);
    assign grant_e = arb_en && e_eff && !grant_p;

    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            p_gnt         <= 1'b0;
            e_gnt         <= 1'b0;
            last_e_q      <= 1'b1;   // player wins the first tie
            worldmap_addr <= 14'd0;
        end else begin
            p_gnt <= grant_p;
            e_gnt <= grant_e;
            if (grant_p) begin
                worldmap_addr <= p_addr;
                last_e_q      <= 1'b0;
            end else if (grant_e) begin
                worldmap_addr <= e_addr;
                last_e_q      <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: tag pipe aligned to the ROM latency, then the valid/data
    // registers capture worldmap_data RD_LAT cycles after the address edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= 2'b00;
            end
            p_valid <= 1'b0;
            e_valid <= 1'b0;
            p_data  <= 2'd0;
            e_data  <= 2'd0;
        end else begin
            tag_q[0] <= {grant_e, grant_p};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            p_valid <= tag_q[RD_LAT-1][0];
            e_valid <= tag_q[RD_LAT-1][1];
            if (tag_q[RD_LAT-1][0]) p_data <= worldmap_data;
            if (tag_q[RD_LAT-1][1]) e_data <= worldmap_data;
        end
    end

endmodule

// File: tb/tb_ss_map_bank_ctrl.sv
module tb_ss_map_bank_ctrl;

  localparam int RD_LAT = 2;   // the ROM model below has RD_LAT-1 = 1 stage

  logic        clk_75 = 1'b0;
  logic        reset;
  logic [7:0]  LocX;
  logic        vblank;
  logic        p_req, e_req;
  logic [13:0] p_addr, e_addr;
  logic        p_gnt, e_gnt, p_valid, e_valid;
  logic [1:0]  p_data, e_data;
  logic [13:0] worldmap_addr;
  logic [1:0]  worldmap_data;
  logic [1:0]  bank_sel;
  logic        bank_switching;
  logic [1:0]  bank_state;

  // ---------------- clock / reset ----------------
  always #5 clk_75 = ~clk_75;

  int cyc = 0;
  always @(posedge clk_75) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  ss_map_bank_ctrl #(
    .LR_LOCX   (8'h7C),
    .LOOP_LOCX (8'hF0),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk_75         (clk_75),
    .reset          (reset),
    .LocX           (LocX),
    .vblank         (vblank),
    .p_req          (p_req),
    .p_addr         (p_addr),
    .p_gnt          (p_gnt),
    .p_valid        (p_valid),
    .p_data         (p_data),
    .e_req          (e_req),
    .e_addr         (e_addr),
    .e_gnt          (e_gnt),
    .e_valid        (e_valid),
    .e_data         (e_data),
    .worldmap_addr  (worldmap_addr),
    .worldmap_data  (worldmap_data),
    .bank_sel       (bank_sel),
    .bank_switching (bank_switching),
    .bank_state     (bank_state)
  );

  // ---------------- map ROM model ----------------
  function automatic logic [1:0] rom_f(input logic [13:0] a, input logic [1:0] bank);
    return a[1:0] ^ a[5:4] ^ a[13:12] ^ bank;
  endfunction

  logic [1:0] rom_q = 2'd0;
  always @(posedge clk_75) rom_q <= rom_f(worldmap_addr, bank_sel);
  assign worldmap_data = rom_q;

  // ---------------- scoreboard ----------------
  logic [1:0]  p_exp_q[$];
  logic [1:0]  e_exp_q[$];
  logic [13:0] p_addr_q[$];
  logic [13:0] e_addr_q[$];
  logic        gnt_log[$];     // 0 = player grant, 1 = enemy grant

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] prev_state = 2'd0;

  always @(negedge clk_75) begin
    if (p_gnt) begin
      gnt_log.push_back(1'b0);
      if (p_addr_q.size() == 0) check("p_gnt_unexpected", 1, 0);
      else check("p_gnt_addr", worldmap_addr, p_addr_q.pop_front());
    end
    if (e_gnt) begin
      gnt_log.push_back(1'b1);
      if (e_addr_q.size() == 0) check("e_gnt_unexpected", 1, 0);
      else check("e_gnt_addr", worldmap_addr, e_addr_q.pop_front());
    end
    if (p_gnt || e_gnt) begin
      check("gnt_one_hot", p_gnt && e_gnt, 0);
      // Only a grant sampled in PENDING may show up in the first DRAIN cycle.
      check("gnt_while_switching", bank_switching && (prev_state != 2'd1), 0);
    end
    if (p_valid) begin
      if (p_exp_q.size() == 0) check("p_valid_unexpected", 1, 0);
      else check("p_data", p_data, p_exp_q.pop_front());
    end
    if (e_valid) begin
      if (e_exp_q.size() == 0) check("e_valid_unexpected", 1, 0);
      else check("e_data", e_data, e_exp_q.pop_front());
    end
    prev_state = bank_state;
  end

  // ---------------- driver ----------------
  int last_lat;

  // Raises req at the current negedge, waits for gnt, drops req in the gnt
  // cycle and returns at that negedge.
  task automatic request(input bit is_e, input logic [13:0] a, input logic [1:0] bank);
    int n;
    int start;
    logic g;
    if (is_e) begin
      e_req = 1'b1; e_addr = a;
      e_addr_q.push_back(a); e_exp_q.push_back(rom_f(a, bank));
    end else begin
      p_req = 1'b1; p_addr = a;
      p_addr_q.push_back(a); p_exp_q.push_back(rom_f(a, bank));
    end
    start = cyc;
    n = 0;
    do begin
      @(negedge clk_75);
      n++;
      g = is_e ? e_gnt : p_gnt;
    end while (g !== 1'b1 && n < 50);
    if (g !== 1'b1) check(is_e ? "e_gnt_timeout" : "p_gnt_timeout", 0, 1);
    last_lat = cyc - start;
    if (is_e) e_req = 1'b0;
    else      p_req = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int sw_seen;
    bit vseen;

    reset = 1'b0; LocX = 8'h00; vblank = 1'b0;
    p_req = 1'b0; e_req = 1'b0; p_addr = 14'd0; e_addr = 14'd0;
    repeat (3) @(negedge clk_75);
    check("reset_outputs",
          {p_gnt, e_gnt, p_valid, e_valid, p_data, e_data, worldmap_addr,
           bank_sel, bank_switching, bank_state}, 0);
    reset = 1'b1;
    @(negedge clk_75);

    // Player-only read: gnt at +1, valid at +3.
    request(1'b0, 14'h0123, 2'd0);
    check("t1_gnt_latency", last_lat, 1);
    check("t1_worldmap_addr", worldmap_addr, 14'h0123);
    @(negedge clk_75);
    check("t1_valid_early", p_valid, 0);
    @(negedge clk_75);
    check("t1_valid", p_valid, 1);
    check("t1_data", p_data, 2'd1);
    @(negedge clk_75);
    check("t1_valid_pulse", p_valid, 0);
    check("t1_data_hold", p_data, 2'd1);

    // Enemy-only read; also leaves the pointer at enemy.
    request(1'b1, 14'h2A5C, 2'd0);
    check("t1e_gnt_latency", last_lat, 1);
    repeat (4) @(negedge clk_75);

    // Both requesters kept busy for 6 requests.
    gnt_log.delete();
    fork
      begin
        request(1'b0, 14'h0011, 2'd0);
        request(1'b0, 14'h0122, 2'd0);
        request(1'b0, 14'h1233, 2'd0);
      end
      begin
        request(1'b1, 14'h3300, 2'd0);
        request(1'b1, 14'h0031, 2'd0);
        request(1'b1, 14'h2002, 2'd0);
      end
    join
    repeat (5) @(negedge clk_75);
    check("t2_grant_count", gnt_log.size(), 6);
    for (int i = 0; i < 6; i++) check("t2_grant_order", gnt_log[i], i % 2);
    check("t2_p_drained", p_exp_q.size(), 0);
    check("t2_e_drained", e_exp_q.size(), 0);

    // Brief excursion to the lr column reverts before vblank.
    LocX = 8'h7B;
    @(negedge clk_75);
    check("t4_idle", bank_state, 0);
    LocX = 8'h7C;
    repeat (3) @(negedge clk_75);
    check("t4_pending", bank_state, 1);
    LocX = 8'h7B;
    @(negedge clk_75);
    check("t4_revert_idle", bank_state, 0);
    vblank = 1'b1;
    repeat (5) @(negedge clk_75);
    check("t4_bank_unchanged", bank_sel, 0);
    check("t4_still_idle", bank_state, 0);
    vblank = 1'b0;

    // lr column held without vblank, then vblank commits the switch.
    LocX = 8'h7C;
    repeat (50) @(negedge clk_75);
    check("t3_pending_hold", bank_state, 1);
    check("t3_bank_hold", bank_sel, 0);
    vblank = 1'b1;
    n = 0; sw_seen = 0;
    do begin
      @(negedge clk_75);
      n++;
      if (bank_switching) sw_seen++;
    end while (bank_sel !== 2'd1 && n < 20);
    check("t3_bank_lr", bank_sel, 1);
    check("t3_switch_in_time", n <= RD_LAT + 2, 1);
    check("t3_switching_seen", sw_seen > 0, 1);
    vblank = 1'b0;
    @(negedge clk_75);
    check("t3_back_idle", {bank_state, bank_switching}, 0);

    // Loop bank with a read granted in the PENDING->DRAIN cycle.
    LocX = 8'hF5;
    @(negedge clk_75);
    check("t5_pending", bank_state, 1);
    vblank = 1'b1;
    p_req = 1'b1; p_addr = 14'h02A5;
    p_addr_q.push_back(14'h02A5); p_exp_q.push_back(rom_f(14'h02A5, 2'd1));
    @(negedge clk_75);
    check("t5_gnt_on_drain", p_gnt, 1);
    check("t5_drain", bank_state, 2);
    p_req = 1'b0;
    vseen = 1'b0;
    fork
      request(1'b1, 14'h0155, 2'd2);
      begin
        n = 0;
        do begin
          @(negedge clk_75);
          n++;
          if (p_valid) begin
            check("t5_valid_before_switch", bank_sel, 1);
            vseen = 1'b1;
          end
        end while (e_gnt !== 1'b1 && n < 30);
        check("t5_held_req_new_bank", bank_sel, 2);
        check("t5_valid_seen_first", vseen, 1);
      end
    join
    vblank = 1'b0;
    repeat (4) @(negedge clk_75);
    check("t5_e_drained", e_exp_q.size(), 0);

    // Reset one cycle after a grant drops the returning read.
    request(1'b0, 14'h3FFF, 2'd2);
    @(negedge clk_75);
    reset = 1'b0;
    LocX = 8'h00;
    p_exp_q.delete();
    e_exp_q.delete();
    #1;
    check("t6_reset_outputs",
          {p_gnt, e_gnt, p_valid, e_valid, p_data, e_data, worldmap_addr,
           bank_sel, bank_switching}, 0);
    repeat (3) begin
      @(negedge clk_75);
      check("t6_no_valid_in_reset", {p_valid, e_valid}, 0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk_75);
    check("t6_no_valid_after", {p_valid, e_valid, bank_sel}, 0);
    gnt_log.delete();
    fork
      request(1'b0, 14'h0AAA, 2'd0);
      request(1'b1, 14'h1555, 2'd0);
    join
    repeat (5) @(negedge clk_75);
    check("t6_tie_count", gnt_log.size(), 2);
    check("t6_tie_player_first", gnt_log[0], 0);

    check("end_p_queue", p_exp_q.size(), 0);
    check("end_e_queue", e_exp_q.size(), 0);
    check("end_p_addr_queue", p_addr_q.size(), 0);
    check("end_e_addr_queue", e_addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
